dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory-side end of the core's dmem load/store interface.
// - Accepts one byte/half/word request at a time on a valid/ready handshake.
// - Performs the access on an internal word-organised RAM after a programmable latency.
// - Returns a response on a second valid/ready handshake.
// - Load data is right-justified and zero-extended; the core applies any sign extension
//   (REGFILE_IN_SEL_MEM_RD_SEXT8/16).
// PARAMETERS
// - ADDR_WIDTH  12  byte-address bits decoded; RAM holds 2**(ADDR_WIDTH-2) 32-bit words
// - LATENCY     2   cycles from request acceptance to resp_valid_o; legal range 1..15
// PORTS
// - clk_i         in   1   clock; all logic on the rising edge
// - reset_n_i     in   1   reset, synchronous, active-low
// - req_valid_i   in   1   request present
// - req_ready_o   out  1   responder can accept a request
// - req_addr_i    in   32  byte address
// - req_we_i      in   1   1 = store, 0 = load
// - req_size_i    in   2   mem_access_size_t: BYTE=0, HALF=1, WORD=2; 3 is illegal
// - req_wdata_i   in   32  store data, right-justified (bits [7:0] for a byte, [15:0] for a half)
// - resp_valid_o  out  1   response present
// - resp_ready_i  in   1   core accepts the response
// - resp_rdata_o  out  32  load data, right-justified, zero-extended; 0 for stores and on error
// - resp_err_o    out  1   access faulted (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: FSM=IDLE, req_ready_o=0 during reset, resp_valid_o=0, resp_rdata_o=0,
//   resp_err_o=0, latency counter=0. RAM contents are not cleared.
// - FSM IDLE: req_ready_o=1. When req_valid_i && req_ready_o, latch addr/we/size/wdata and go to WAIT.
// - WAIT: req_ready_o=0; counter counts up from 1.
//   - If counter == LATENCY: perform the access, register rdata/err, go to RESP.
//   - With LATENCY=1, RESP is entered the cycle after acceptance.
// - RESP: resp_valid_o=1; rdata/err are held stable until resp_ready_i=1, then return to IDLE.
//   - There is no same-cycle re-accept: req_ready_o=1 no earlier than the cycle after the
//     response handshake.
// - Only one request is outstanding at a time. Back-to-back throughput is one request per
//   LATENCY+2 cycles.
// - Store byte lanes, with off = addr[1:0]:
//   - BYTE: lane off receives wdata[7:0].
//   - HALF: lanes off and off+1 receive wdata[15:0].
//   - WORD: all lanes receive wdata.
//   - Untouched lanes keep their value.
//   - The write commits exactly once, on the WAIT->RESP edge.
// - Load: word at addr[ADDR_WIDTH-1:2], shifted right by 8*off, masked to 8/16/32 bits.
// - Response fields are don't-care in the core while resp_valid_o=0 but must be 0 after reset.
// - Reset mid-operation (WAIT or RESP): the pending request is dropped.
//   - A store still in WAIT never commits.
//   - A store already in RESP is retained in RAM.
// - req_* inputs may change freely outside the accept cycle; only the accept-cycle values are used.
// CONFIGURATION
// - Macro DMEM_RESPONDER_ERR_CHECK_EN.
// - Defined: resp_err_o=1 and no RAM write and rdata=0 when any of the following hold:
//   - req_size_i == 3;
//   - HALF with addr[0]=1;
//   - WORD with addr[1:0] != 0;
//   - addr[31:ADDR_WIDTH] != 0.
//   The timing of a faulting access is identical to a normal one (still LATENCY cycles).
// - Undefined:
//   - resp_err_o is tied 0.
//   - Upper address bits are ignored (accesses wrap modulo RAM size).
//   - Misaligned HALF/WORD force-align: addr[0] is cleared for HALF, addr[1:0] for WORD.
//   - Size 3 is treated as WORD.
// TESTING
// - Reset then idle -> resp_valid_o=0, resp_err_o=0, resp_rdata_o=0; req_ready_o=1 in the
//   first cycle after reset_n_i rises.
// - With LATENCY=2: SW 0x100 = 0xDEADBEEF, then LW 0x100 -> resp_valid_o two cycles after each
//   accept; rdata = 0x0000_0000 for the store and 0xDEADBEEF for the load.
// - After the previous write: SB 0x101 = 0x55, then LBU 0x101, then LW 0x100 ->
//   rdata = 0x00000055, then 0xDEAD55EF. Then LH 0x102 -> rdata = 0x0000DEAD.
// - Backpressure: load response with resp_ready_i=0 for 5 cycles -> resp_valid_o and rdata held
//   constant, req_ready_o=0 throughout; new req_valid_i ignored until after the handshake.
// - With ERR_CHECK_EN: SH 0x103, LW 0x102, SW to 0x0000_1000 (ADDR_WIDTH=12), size=3 ->
//   each gives resp_err_o=1, rdata=0, RAM unchanged.
//   Without ERR_CHECK_EN: LW 0x102 returns the word at 0x100.
// - Reset asserted one cycle after a SW 0x200 = 0x12345678 accept (in WAIT); after reset,
//   LW 0x200 -> previous contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the core dmem port and dmem_responder
// Purpose: groups the request handshake (valid/ready plus addr/we/size/wdata) and the
//          response handshake (valid/ready plus rdata/err) of the dmem load/store port.
// Modports:
//   master - core side: drives the request fields and resp_ready_i
//   slave  - responder side: drives req_ready_o and the response fields
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder for the core's dmem load/store port
// Purpose: accepts one byte/half/word request at a time, performs it on an internal
//          word-organised RAM after LATENCY cycles and returns a response. Load data is
//          right-justified and zero-extended.
// Parameters: ADDR_WIDTH (byte-address bits decoded), LATENCY (1..15 cycles accept->response)
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - synchronous active-low reset
//   bus        - dmem_responder_if.slave: req_valid/ready/addr/we/size/wdata,
//                resp_valid/ready/rdata/err
// Optional feature: define DMEM_RESPONDER_ERR_CHECK_EN to fault misaligned, oversized
//   (size 3) and out-of-range accesses; otherwise accesses force-align and wrap.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input logic            clk_i,
  input logic            reset_n_i,
  dmem_responder_if.slave bus
);

  localparam int         WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [31:0]             mem [WORDS];

  logic                    req_ready;
  logic                    resp_valid;
  logic                    accept;
  logic                    access_now;
  logic                    mem_we;

  logic [1:0]              off;
  logic [1:0]              eff_size;
  logic                    acc_err;
  logic [ADDR_WIDTH-3:0]   widx;
  logic [31:0]             word_rd;
  logic [31:0]             load_val;
  logic [3:0]              be;
  logic [31:0]             wr_data_sh;
  logic [31:0]             wr_word;

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
  logic                    oob_q;
`endif

  assign accept     = bus.req_valid_i && req_ready;
  assign access_now = (state_q == WAIT) && (cnt_q == LAT);
  // Reset gating keeps a store that is still in WAIT from ever committing.
  assign mem_we     = access_now && we_q && !acc_err && reset_n_i;

  // Next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = reset_n_i;
        if (bus.req_valid_i && reset_n_i) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAT) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access datapath: lane offset, fault detection, load extraction and store merge
  always_comb begin
    off      = addr_q[1:0];
    eff_size = size_q;
    acc_err  = 1'b0;
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    acc_err = (size_q == 2'd3) ||
              ((size_q == 2'd1) && addr_q[0]) ||
              ((size_q == 2'd2) && (addr_q[1:0] != 2'd0)) ||
              oob_q;
`else
    // Size 3 behaves as a word; misaligned halves/words drop their low address bits.
    if (size_q == 2'd3) eff_size = 2'd2;
    if (eff_size == 2'd1) off[0] = 1'b0;
    else if (eff_size == 2'd2) off = 2'd0;
`endif
    widx     = addr_q[ADDR_WIDTH-1:2];
    word_rd  = mem[widx];
    load_val = word_rd >> {off, 3'b000};
    case (eff_size)
      2'd0:    load_val = {24'd0, load_val[7:0]};
      2'd1:    load_val = {16'd0, load_val[15:0]};
      default: load_val = load_val;
    endcase
    case (eff_size)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      default: be = 4'b1111;
    endcase
    be         = be << off;
    wr_data_sh = wdata_q << {off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? wr_data_sh[8*i +: 8] : word_rd[8*i +: 8];
    end
  end

  // Control state, latency counter and response registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= 4'd1;
      end else if (state_q == WAIT) begin
        if (access_now) begin
          rdata_q <= (acc_err || we_q) ? 32'd0 : load_val;
          err_q   <= acc_err;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  // Request capture; only the accept-cycle values matter
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= bus.req_addr_i[ADDR_WIDTH-1:0];
      we_q    <= bus.req_we_i;
      size_q  <= bus.req_size_i;
      wdata_q <= bus.req_wdata_i;
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
      oob_q   <= (bus.req_addr_i[31:ADDR_WIDTH] != '0);
`endif
    end
  end

  // RAM is never cleared; one write on the WAIT->RESP edge
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[widx] <= wr_word;
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int AW  = 12;
  localparam int LAT = 2;
  localparam int MEMB = 2 ** AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-addressed reference memory and the one outstanding request
  logic [7:0]  mm [MEMB];
  bit          busy = 0;
  bit          committed;
  int          cyc = 0;
  int          acc_cyc;
  logic        p_err, p_we;
  logic [31:0] p_rd, p_wd;
  int          p_start, p_n;

  function automatic void model_accept(input logic [31:0] a, input logic we,
                                       input logic [1:0] sz, input logic [31:0] wd);
    p_n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    p_err = 1'b0;
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    p_err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
            (a >= MEMB);
    p_start = int'(a % MEMB);
`else
    p_start = int'(a % MEMB) / p_n * p_n;
`endif
    p_we = we;
    p_wd = wd;
    p_rd = 32'd0;
    if (!p_err && !we)
      for (int i = 0; i < p_n; i++) p_rd = p_rd | (32'(mm[p_start + i]) << (8 * i));
  endfunction

  function automatic void model_commit();
    if (p_we && !p_err)
      for (int i = 0; i < p_n; i++) mm[p_start + i] = p_wd[8*i +: 8];
  endfunction

  // Compare process: every cycle, checked half a cycle away from the active edge
  always @(negedge clk) begin
    bit ev;
    cyc++;
    if (!reset_n) begin
      busy = 0;
      chk("ready_in_reset", 32'(bus.req_ready_o), 32'd0);
    end else begin
      ev = busy && (cyc - acc_cyc >= LAT + 1);
      chk("req_ready", 32'(bus.req_ready_o), 32'(!busy));
      chk("resp_valid", 32'(bus.resp_valid_o), 32'(ev));
      if (ev) begin
        if (!committed) begin
          model_commit();
          committed = 1;
        end
        chk("resp_rdata", bus.resp_rdata_o, p_rd);
        chk("resp_err", 32'(bus.resp_err_o), 32'(p_err));
        if (bus.resp_ready_i) busy = 0;
      end else if (!busy && bus.req_valid_i) begin
        model_accept(bus.req_addr_i, bus.req_we_i, bus.req_size_i, bus.req_wdata_i);
        busy = 1;
        acc_cyc = cyc;
        committed = 0;
      end
    end
  end

  // One request/response; hold = cycles of response backpressure
  task automatic xact(input logic [31:0] a, input logic we, input logic [1:0] sz,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_we_i    = we;
    bus.req_size_i  = sz;
    bus.req_wdata_i = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready_o && n < 50);
    if (!bus.req_ready_o) begin
      tests++; fails++;
      $display("FAIL accept_timeout actual=req_ready_o 0 expected=1");
    end
    @(posedge clk); #1;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = $urandom;
    bus.req_wdata_i  = $urandom;
    bus.resp_ready_i = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid_o && n < 50);
    if (!bus.resp_valid_o) begin
      tests++; fails++;
      $display("FAIL resp_timeout actual=resp_valid_o 0 expected=1");
    end
    rd = bus.resp_rdata_o;
    er = bus.resp_err_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = $urandom;
      bus.req_we_i    = 1'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp_rdata", bus.resp_rdata_o, rd);
      chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic dir(input string name, input logic [31:0] a, input logic we,
                     input logic [1:0] sz, input logic [31:0] wd, input int hold,
                     input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    xact(a, we, sz, wd, hold, rd, er);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = 32'd0;
    bus.req_we_i     = 1'b0;
    bus.req_size_i   = 2'd0;
    bus.req_wdata_i  = 32'd0;
    bus.resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_err", 32'(bus.resp_err_o), 32'd0);
    @(posedge clk); #1;

    for (int w = 0; w < MEMB / 4; w++) xact(32'(w * 4), 1'b1, 2'd2, $urandom, 0, rd, er);

    dir("sw100", 32'h100, 1'b1, 2'd2, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    dir("lw100", 32'h100, 1'b0, 2'd2, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    dir("sb101", 32'h101, 1'b1, 2'd0, 32'hFFFFFF55, 0, 32'h0, 1'b0);
    dir("lbu101", 32'h101, 1'b0, 2'd0, 32'h0, 0, 32'h00000055, 1'b0);
    dir("lw100b", 32'h100, 1'b0, 2'd2, 32'h0, 0, 32'hDEAD55EF, 1'b0);
    dir("lh102", 32'h102, 1'b0, 2'd1, 32'h0, 0, 32'h0000DEAD, 1'b0);
    dir("bp_lw100", 32'h100, 1'b0, 2'd2, 32'h0, 5, 32'hDEAD55EF, 1'b0);
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    dir("err_sh103", 32'h103, 1'b1, 2'd1, 32'h1234, 0, 32'h0, 1'b1);
    dir("err_lw102", 32'h102, 1'b0, 2'd2, 32'h0, 0, 32'h0, 1'b1);
    dir("err_sw1000", 32'h1000, 1'b1, 2'd2, 32'hCAFEF00D, 0, 32'h0, 1'b1);
    dir("err_sz3", 32'h100, 1'b1, 2'd3, 32'h0BADF00D, 0, 32'h0, 1'b1);
    dir("err_unchanged", 32'h100, 1'b0, 2'd2, 32'h0, 0, 32'hDEAD55EF, 1'b0);
`else
    dir("align_lw102", 32'h102, 1'b0, 2'd2, 32'h0, 0, 32'hDEAD55EF, 1'b0);
`endif

    // Reset while a store sits in WAIT: the store must be lost
    dir("sw200", 32'h200, 1'b1, 2'd2, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h200;
    bus.req_we_i    = 1'b1;
    bus.req_size_i  = 2'd2;
    bus.req_wdata_i = 32'h12345678;
    @(negedge clk);
    chk("pre_rst_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    dir("lw200_after_rst", 32'h200, 1'b0, 2'd2, 32'h0, 0, 32'hA5A5A5A5, 1'b0);

    for (int t = 0; t < 300; t++) begin
      a = 32'($urandom_range(0, MEMB - 1));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
      xact(a, 1'($urandom), 2'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, rd, er);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
